hft_order_book: RTL and testbench

//  Single-side (bid) limit order book for one instrument in the HFT pipeline.

---
 rtl/hft_order_book.sv | 193 +++++++++++++++++++
 tb/tb_hft_order_book.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/hft_order_book.sv
// Single-side (bid) limit order book: add/cancel/modify requests over DEPTH slots, best price on max_*.
// Add/no-op complete in 2 cycles; cancel/modify scan one slot per cycle, cancel of best adds a DEPTH-cycle rescan.
module hft_order_book #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic [31:0] order_id,
  input  logic [31:0] quantity,
  input  logic [63:0] price,
  input  logic [2:0]  req_type,
  output logic [31:0] max_order_id,
  output logic [31:0] max_quantity,
  output logic [63:0] max_price,
  output logic        ready
);
  localparam logic [2:0] REQ_ADD    = 3'b100;
  localparam logic [2:0] REQ_CANCEL = 3'b001;
  localparam logic [2:0] REQ_MODIFY = 3'b010;

  typedef enum logic [2:0] {IDLE, EXEC, SCAN, RESCAN, DONE, WAITLOW} state_t;
  state_t state;

  logic [DEPTH-1:0] slot_vld;
  logic [31:0]      slot_id    [DEPTH];
  logic [31:0]      slot_qty   [DEPTH];
  logic [63:0]      slot_price [DEPTH];

  logic [IDX_W:0]   count;
  logic [IDX_W-1:0] best_idx;
  logic [2:0]       req_q;
  logic [31:0]      id_q;
  logic [31:0]      qty_q;
  logic [63:0]      price_q;
  logic [IDX_W-1:0] ptr;
  logic             cand_found;
  logic [63:0]      cand_price;
  logic [IDX_W-1:0] cand_idx;

  logic [IDX_W-1:0] free_idx;
  logic             full;
  logic             ptr_hit;
  logic             ptr_last;
  logic             add_we;
  logic             mod_we;
  logic             nxt_found;
  logic [63:0]      nxt_price;
  logic [IDX_W-1:0] nxt_idx;

  // Lowest-index free slot
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!slot_vld[i]) free_idx = IDX_W'(i);
    end
  end

  assign full     = (count == (IDX_W + 1)'(DEPTH));
  assign ptr_hit  = slot_vld[ptr] && (slot_id[ptr] == id_q);
  assign ptr_last = (ptr == IDX_W'(DEPTH - 1));
  assign add_we   = (state == EXEC) && (req_q == REQ_ADD) && !full;
  assign mod_we   = (state == SCAN) && (req_q == REQ_MODIFY) && ptr_hit;

  // Strict compare while walking upward keeps the lowest index on price ties
  always_comb begin
    nxt_found = cand_found;
    nxt_price = cand_price;
    nxt_idx   = cand_idx;
    if (slot_vld[ptr] && (!cand_found || slot_price[ptr] > cand_price)) begin
      nxt_found = 1'b1;
      nxt_price = slot_price[ptr];
      nxt_idx   = ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (add_we) begin
      slot_id[free_idx]    <= id_q;
      slot_qty[free_idx]   <= qty_q;
      slot_price[free_idx] <= price_q;
    end
    if (mod_we) slot_qty[ptr] <= qty_q;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state        <= IDLE;
      slot_vld     <= '0;
      count        <= '0;
      best_idx     <= '0;
      req_q        <= '0;
      id_q         <= '0;
      qty_q        <= '0;
      price_q      <= '0;
      ptr          <= '0;
      cand_found   <= 1'b0;
      cand_price   <= '0;
      cand_idx     <= '0;
      max_order_id <= '0;
      max_quantity <= '0;
      max_price    <= '0;
      ready        <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            req_q   <= req_type;
            id_q    <= order_id;
            qty_q   <= quantity;
            price_q <= price;
            state   <= EXEC;
          end
        end
        EXEC: begin
          ptr <= '0;
          if (req_q == REQ_ADD) begin
            if (!full) begin
              slot_vld[free_idx] <= 1'b1;
              count              <= count + (IDX_W + 1)'(1);
              if (count == '0 || price_q > max_price) begin
                best_idx     <= free_idx;
                max_order_id <= id_q;
                max_quantity <= qty_q;
                max_price    <= price_q;
              end
            end
            state <= DONE;
          end else if (req_q == REQ_CANCEL || req_q == REQ_MODIFY) begin
            state <= SCAN;
          end else begin
            state <= DONE;
          end
        end
        SCAN: begin
          if (ptr_hit) begin
            if (req_q == REQ_CANCEL) begin
              slot_vld[ptr] <= 1'b0;
              count         <= count - (IDX_W + 1)'(1);
              if (ptr == best_idx) begin
                ptr        <= '0;
                cand_found <= 1'b0;
                cand_price <= '0;
                cand_idx   <= '0;
                state      <= RESCAN;
              end else begin
                state <= DONE;
              end
            end else begin
              if (ptr == best_idx) max_quantity <= qty_q;
              state <= DONE;
            end
          end else if (ptr_last) begin
            state <= DONE;
          end else begin
            ptr <= ptr + IDX_W'(1);
          end
        end
        RESCAN: begin
          if (ptr_last) begin
            if (nxt_found) begin
              best_idx     <= nxt_idx;
              max_order_id <= slot_id[nxt_idx];
              max_quantity <= slot_qty[nxt_idx];
              max_price    <= nxt_price;
            end else begin
              best_idx     <= '0;
              max_order_id <= '0;
              max_quantity <= '0;
              max_price    <= '0;
            end
            state <= DONE;
          end else begin
            cand_found <= nxt_found;
            cand_price <= nxt_price;
            cand_idx   <= nxt_idx;
            ptr        <= ptr + IDX_W'(1);
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= WAITLOW;
        end
        WAITLOW: begin
          if (!valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hft_order_book.sv
// Directed bench for hft_order_book: hand-computed best-order values, latencies and ready pulse counts.
module tb_hft_order_book;
  localparam logic [2:0] ADD = 3'b100, CANCEL = 3'b001, MODIFY = 3'b010;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] order_id = '0;
  logic [31:0] quantity = '0;
  logic [63:0] price = '0;
  logic [2:0]  req_type = '0;
  logic [31:0] max_order_id;
  logic [31:0] max_quantity;
  logic [63:0] max_price;
  logic        ready;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;

  hft_order_book #(.DEPTH(256), .IDX_W(8)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .order_id(order_id),
    .quantity(quantity), .price(price), .req_type(req_type),
    .max_order_id(max_order_id), .max_quantity(max_quantity),
    .max_price(max_price), .ready(ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ready) ready_cnt++;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request, returns cycles from capture edge to ready, then lets the FSM return to IDLE
  task automatic do_req(input logic [2:0] t, input logic [31:0] id, input logic [31:0] q,
                        input logic [63:0] p, output int lat);
    int edges;
    req_type = t; order_id = id; quantity = q; price = p; valid = 1'b1;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!ready && edges < 2000);
    if (!ready) check_val("req_timeout", 64'(ready), 64'd1);
    valid = 1'b0;
    lat = edges - 1;
    @(posedge clk); #1;
  endtask

  task automatic check_max(input string tag, input logic [31:0] id, input logic [31:0] q,
                           input logic [63:0] p);
    check_val({tag, "_id"}, 64'(max_order_id), 64'(id));
    check_val({tag, "_qty"}, 64'(max_quantity), 64'(q));
    check_val({tag, "_price"}, max_price, p);
  endtask

  initial begin
    int lat;
    int bad_lat;
    int rc;

    // 1. reset
    repeat (6) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check_max("reset", 32'd0, 32'd0, 64'd0);
    check_val("reset_ready", 64'(ready), 64'd0);
    repeat (5) @(posedge clk);
    #1 check_val("idle_no_ready", 64'(ready_cnt), 64'd0);

    // 2. add ids 0..199
    bad_lat = 0;
    for (int i = 0; i < 200; i++) begin
      do_req(ADD, 32'(i), 32'h435365, 64'(20 * i), lat);
      if (lat != 2) bad_lat++;
    end
    check_val("add_latency_bad", 64'(bad_lat), 64'd0);
    check_val("add_ready_cnt", 64'(ready_cnt), 64'd200);
    check_max("after_adds", 32'd199, 32'h435365, 64'd3980);

    // 3. cancel non-best, then best
    rc = ready_cnt;
    do_req(CANCEL, 32'd40, 32'd0, 64'd0, lat);
    check_val("cancel40_lat", 64'(lat), 64'd43);
    check_val("cancel40_pulses", 64'(ready_cnt - rc), 64'd1);
    check_max("cancel40", 32'd199, 32'h435365, 64'd3980);
    do_req(CANCEL, 32'd199, 32'd0, 64'd0, lat);
    check_val("cancel199_lat", 64'(lat), 64'd458);
    check_max("cancel199", 32'd198, 32'h435365, 64'd3960);

    // 4. modify best qty, cancel absent id
    do_req(MODIFY, 32'd198, 32'hF, 64'd0, lat);
    check_val("modify_lat", 64'(lat), 64'd201);
    check_max("modify198", 32'd198, 32'hF, 64'd3960);
    rc = ready_cnt;
    do_req(CANCEL, 32'd999, 32'd0, 64'd0, lat);
    check_val("absent_lat", 64'(lat), 64'd258);
    check_val("absent_pulses", 64'(ready_cnt - rc), 64'd1);
    check_max("absent", 32'd198, 32'hF, 64'd3960);

    // 5. fill remaining 58 slots (40, 199, 200..255) with low prices
    for (int j = 0; j < 58; j++) do_req(ADD, 32'(1000 + j), 32'd1, 64'd100, lat);
    check_max("filled", 32'd198, 32'hF, 64'd3960);
    rc = ready_cnt;
    do_req(ADD, 32'd5000, 32'd3, 64'hFFFF, lat);
    check_val("full_add_lat", 64'(lat), 64'd2);
    check_val("full_add_pulses", 64'(ready_cnt - rc), 64'd1);
    check_max("full_add", 32'd198, 32'hF, 64'd3960);
    do_req(CANCEL, 32'd1000, 32'd0, 64'd0, lat);
    do_req(ADD, 32'd6000, 32'd7, 64'd3960, lat);
    check_max("equal_price_add", 32'd198, 32'hF, 64'd3960);
    do_req(CANCEL, 32'd1001, 32'd0, 64'd0, lat);
    do_req(ADD, 32'd7000, 32'd8, 64'd3960, lat);
    // slots 40 and 199 tie at 3960: lower index must win
    do_req(CANCEL, 32'd198, 32'd0, 64'd0, lat);
    check_val("tie_rescan_lat", 64'(lat), 64'd457);
    check_max("tie_rescan", 32'd6000, 32'd7, 64'd3960);
    // duplicate id lands in slot 198, ahead of the original in slot 199
    do_req(ADD, 32'd7000, 32'd2, 64'd10, lat);
    do_req(CANCEL, 32'd7000, 32'd0, 64'd0, lat);
    check_val("dup_cancel_lat", 64'(lat), 64'd201);
    check_max("dup_cancel", 32'd6000, 32'd7, 64'd3960);

    // 6. reset during the rescan triggered by cancelling best (slot 40)
    rc = ready_cnt;
    req_type = CANCEL; order_id = 32'd6000; quantity = '0; price = '0; valid = 1'b1;
    repeat (60) @(posedge clk);
    #1 resetn = 1'b1;
    valid = 1'b0;
    #1;
    check_max("mid_reset", 32'd0, 32'd0, 64'd0);
    check_val("mid_reset_ready", 64'(ready), 64'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_val("mid_reset_no_pulse", 64'(ready_cnt - rc), 64'd0);

    do_req(ADD, 32'd77, 32'd9, 64'd500, lat);
    check_max("post_reset_add", 32'd77, 32'd9, 64'd500);
    do_req(CANCEL, 32'd77, 32'd0, 64'd0, lat);
    check_val("cancel_only_lat", 64'(lat), 64'd259);
    check_max("cancel_only", 32'd0, 32'd0, 64'd0);

    // no-op request type
    do_req(3'b111, 32'd1, 32'd1, 64'd1, lat);
    check_val("noop_lat", 64'(lat), 64'd2);
    check_max("noop", 32'd0, 32'd0, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
